trace_dump: RTL and testbench

TRACE_DUMP -- requirements
Module: trace_dump

---
 rtl/trace_dump_if.sv | 32 +++
 rtl/trace_dump.sv | 138 +++++++++++++
 tb/tb_trace_dump.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/trace_dump_if.sv
// Bundles the dump request, capture-RAM read port and UART byte handshake of trace_dump.
// master = the dump engine, slave = the capture/UART side.
interface trace_dump_if;
  logic       dump_start;
  logic [1:0] dump_chan;
  logic       cap_done;
  logic [8:0] trace_end;
  logic       en;
  logic [8:0] addr;
  logic [7:0] ch1_rdata;
  logic [7:0] ch2_rdata;
  logic [7:0] ch3_rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       dump_done;
  logic       clr_cap_done;
  logic       err;

  modport master (
    input  dump_start, dump_chan, cap_done, trace_end,
    input  ch1_rdata, ch2_rdata, ch3_rdata, tx_ready,
    output en, addr, tx_data, tx_valid, busy, dump_done, clr_cap_done, err
  );

  modport slave (
    output dump_start, dump_chan, cap_done, trace_end,
    output ch1_rdata, ch2_rdata, ch3_rdata, tx_ready,
    input  en, addr, tx_data, tx_valid, busy, dump_done, clr_cap_done, err
  );
endinterface

// File: rtl/trace_dump.sv
// Streams one captured channel (512 samples, oldest first) from capture RAM to a UART byte port.
// Optional macro TRACE_DUMP_HDR_EN prefixes each dump with header bytes 0xA5, {6'b0, chan}.
module trace_dump (
  input  logic        clk,
  input  logic        rst,
  trace_dump_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] chan_q, chan_d;
  logic [8:0] addr_q, addr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] txd_q, txd_d;
  logic       txv_q, txv_d;
  logic       err_q, err_d;
`ifdef TRACE_DUMP_HDR_EN
  // 2 = 0xA5 on the wire, 1 = channel byte on the wire, 0 = samples
  logic [1:0] hdr_q, hdr_d;
`endif

  logic       xfer;
  logic       last;
  logic [7:0] rdata_sel;

  assign xfer = txv_q & bus.tx_ready;
  assign last = (cnt_q == 9'h1FF);

  always_comb begin
    case (chan_q)
      2'd1:    rdata_sel = bus.ch2_rdata;
      2'd2:    rdata_sel = bus.ch3_rdata;
      default: rdata_sel = bus.ch1_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    err_d   = 1'b0;
`ifdef TRACE_DUMP_HDR_EN
    hdr_d   = hdr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          if (!bus.cap_done || bus.dump_chan == 2'd3) begin
            err_d = 1'b1;
          end else begin
            chan_d = bus.dump_chan;
            // oldest sample sits just past the last written address
            addr_d = bus.trace_end + 9'd1;
            cnt_d  = 9'd0;
`ifdef TRACE_DUMP_HDR_EN
            txd_d   = 8'hA5;
            txv_d   = 1'b1;
            hdr_d   = 2'd2;
            state_d = SEND;
`else
            state_d = READ;
`endif
          end
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        txd_d   = rdata_sel;
        txv_d   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
`ifdef TRACE_DUMP_HDR_EN
          if (hdr_q == 2'd2) begin
            txd_d = {6'b0, chan_q};
            hdr_d = 2'd1;
          end else if (hdr_q == 2'd1) begin
            txv_d   = 1'b0;
            hdr_d   = 2'd0;
            state_d = READ;
          end else
`endif
          begin
            txv_d = 1'b0;
            if (last) begin
              state_d = DONE;
            end else begin
              addr_d  = addr_q + 9'd1;
              cnt_d   = cnt_q + 9'd1;
              state_d = READ;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      chan_q  <= 2'd0;
      addr_q  <= 9'd0;
      cnt_q   <= 9'd0;
      txd_q   <= 8'd0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef TRACE_DUMP_HDR_EN
      hdr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
`ifdef TRACE_DUMP_HDR_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

  assign bus.en           = (state_q == READ);
  assign bus.addr         = addr_q;
  assign bus.tx_data      = txd_q;
  assign bus.tx_valid     = txv_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.dump_done    = (state_q == DONE);
  assign bus.clr_cap_done = (state_q == DONE);
  assign bus.err          = err_q;
endmodule

// File: tb/tb_trace_dump.sv
// Randomized self-checking bench for trace_dump: RAM model, transfer monitor and an
// index-based reference of the expected byte stream.
module tb_trace_dump;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_dump_if bus();
  trace_dump dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef TRACE_DUMP_HDR_EN
  localparam int HDR = 2;
  localparam int LAT = 1;
`else
  localparam int HDR = 0;
  localparam int LAT = 3;
`endif

  logic [7:0] ram [3][512];
  always @(posedge clk) begin
    if (bus.en) begin
      bus.ch1_rdata <= ram[0][bus.addr];
      bus.ch2_rdata <= ram[1][bus.addr];
      bus.ch3_rdata <= ram[2][bus.addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rxq[$];
  logic [8:0] enq[$];
  int err_cnt, done_cnt, clr_cnt;

  // transfer at the coming posedge is decided by values stable at this negedge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid && bus.tx_ready) rxq.push_back(bus.tx_data);
      if (bus.en) enq.push_back(bus.addr);
      if (bus.err) err_cnt++;
      if (bus.dump_done) done_cnt++;
      if (bus.clr_cap_done) clr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {bus.en, bus.addr, bus.tx_data, bus.tx_valid, bus.busy,
            bus.dump_done, bus.clr_cap_done, bus.err};
  endfunction

  function automatic logic [7:0] exp_byte(input int ch, input logic [8:0] te, input int k);
`ifdef TRACE_DUMP_HDR_EN
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'(ch);
`endif
    return ram[ch][(int'(te) + 1 + k - HDR) % 512];
  endfunction

  task automatic clear_mon();
    rxq.delete();
    enq.delete();
    err_cnt = 0;
    done_cnt = 0;
    clr_cnt = 0;
  endtask

  task automatic reject(input logic cap, input logic [1:0] ch, input string tag);
    clear_mon();
    @(posedge clk); #1;
    bus.cap_done = cap; bus.dump_chan = ch; bus.dump_start = 1'b1;
    @(posedge clk); #1;
    bus.dump_start = 1'b0;
    chk({tag, "_err"}, bus.err, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    @(posedge clk); #1;
    chk({tag, "_err_one_cycle"}, bus.err, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_no_en"}, enq.size(), 0);
    chk({tag, "_err_count"}, err_cnt, 1);
    chk({tag, "_busy_after"}, bus.busy, 0);
  endtask

  // rmode 0: tx_ready always 1, 1: random. stall_idx/abort_at < 0 disables.
  task automatic run_dump(input int ch, input logic [8:0] te, input int rmode,
                          input int stall_idx, input int abort_at, input bit poke,
                          input string tag);
    int cyc, first_v, stall_left, se, nmis;
    logic [7:0] sd;
    logic [8:0] sa;
    bit stable, stall_chk;
    clear_mon();
    @(posedge clk); #1;
    bus.cap_done = 1'b1; bus.dump_chan = 2'(ch); bus.trace_end = te;
    bus.dump_start = 1'b1;
    bus.tx_ready = (rmode == 0);
    cyc = 0; first_v = -1; stall_left = 10; stable = 1; stall_chk = 0;
    se = 0; sd = 8'd0; sa = 9'd0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus.dump_start = 1'b0;
        bus.trace_end = 9'($urandom);
        bus.dump_chan = 2'($urandom);
        bus.cap_done = 1'($urandom);
      end else if (poke) begin
        bus.dump_start = (cyc == 40 || cyc == 301);
      end
      if (bus.tx_valid && first_v < 0) first_v = cyc;
      if (abort_at >= 0 && rxq.size() == abort_at) begin
        rst = 1'b1;
        #1;
        chk({tag, "_rst_outs"}, outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_outs_held"}, outs(), 0);
        chk({tag, "_abort_no_done"}, done_cnt, 0);
        chk({tag, "_abort_no_clr"}, clr_cnt, 0);
        bus.tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (bus.tx_valid && stall_idx >= 0 && rxq.size() == stall_idx && stall_left > 0) begin
        if (stall_left == 10) begin
          sd = bus.tx_data; sa = bus.addr; se = enq.size();
        end else if (bus.tx_data !== sd || bus.addr !== sa || bus.tx_valid !== 1'b1) begin
          stable = 0;
        end
        stall_left--;
        bus.tx_ready = 1'b0;
      end else begin
        if (stall_idx >= 0 && stall_left == 0 && !stall_chk) begin
          stall_chk = 1;
          chk({tag, "_stall_stable"}, stable, 1);
          chk({tag, "_stall_no_en"}, enq.size(), se);
          chk({tag, "_stall_data"}, bus.tx_data, exp_byte(ch, te, stall_idx));
        end
        bus.tx_ready = (rmode == 0) ? 1'b1 : 1'($urandom);
      end
    end
    bus.tx_ready = 1'b0;
    chk({tag, "_timeout"}, cyc < 20000, 1);
    chk({tag, "_latency"}, first_v, LAT);
    chk({tag, "_nbytes"}, rxq.size(), 512 + HDR);
    nmis = 0;
    for (int k = 0; k < rxq.size() && k < 512 + HDR; k++)
      if (rxq[k] !== exp_byte(ch, te, k)) nmis++;
    chk({tag, "_byte_mismatches"}, nmis, 0);
    chk({tag, "_en_pulses"}, enq.size(), 512);
    nmis = 0;
    for (int k = 0; k < enq.size() && k < 512; k++)
      if (enq[k] !== 9'((int'(te) + 1 + k) % 512)) nmis++;
    chk({tag, "_addr_mismatches"}, nmis, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_clr_pulses"}, clr_cnt, 1);
    chk({tag, "_no_err"}, err_cnt, 0);
    chk({tag, "_idle_after"}, bus.busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[0][i] = 8'(i);
      ram[1][i] = 8'($urandom);
      ram[2][i] = 8'($urandom);
    end
    bus.dump_start = 1'b0; bus.dump_chan = 2'd0; bus.cap_done = 1'b0;
    bus.trace_end = 9'd0; bus.tx_ready = 1'b0;
    #12;
    chk("reset_outs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_outs", outs(), 0);

    run_dump(0, 9'h0A0, 0, -1, -1, 0, "basic_wrap");
    reject(1'b0, 2'd0, "rej_nocap");
    reject(1'b1, 2'd3, "rej_chan3");
    run_dump(1, 9'($urandom), 1, -1, -1, 1, "rand_poke");
    run_dump(2, 9'h1FF, 0, HDR + 5, -1, 0, "stall");
    run_dump(0, 9'($urandom), 0, -1, HDR + 100, 0, "abort");
    run_dump(2, 9'($urandom), 1, -1, -1, 0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
